// File: rtl/mux3_1_pkg.sv
// mux3_1_pkg: shared definitions for the three-input selector.
//   sel_t          2-bit select type
//   SEL_IN0..2     select codes for the three data sources
//   SEL_RSVD       reserved select code, flagged as an error
//   is_rsvd()      true when a select value is the reserved code
package mux3_1_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_IN0  = 2'b00;
  localparam sel_t SEL_IN1  = 2'b01;
  localparam sel_t SEL_IN2  = 2'b10;
  localparam sel_t SEL_RSVD = 2'b11;

  function automatic logic is_rsvd(input sel_t s);
    return (s == SEL_RSVD);
  endfunction

endpackage

// File: rtl/mux3_1_if.sv
// mux3_1_if: data/select bus of the three-input selector.
//   in0, in1, in2  data sources (WIDTH bits)
//   sel            source select (sel_t)
//   out            selected data (WIDTH bits)
//   sel_err        registered illegal-select pulse
//   err_cnt        saturating illegal-select count (CNT_W bits)
// Modports: master drives sources/select, slave is the selector.
interface mux3_1_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
);
  import mux3_1_pkg::*;

  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  sel_t             sel;
  logic [WIDTH-1:0] out;
  logic             sel_err;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    output in0, in1, in2, sel,
    input  out, sel_err, err_cnt
  );

  modport slave (
    input  in0, in1, in2, sel,
    output out, sel_err, err_cnt
  );

endinterface

// File: rtl/mux3_1_err_cnt.sv
// mux3_1_err_cnt: saturating event counter.
//   clk   system clock, counts on rising edge
//   rst   asynchronous active-high clear
//   inc   count enable for this edge
//   cnt   current count; holds at all-ones, never wraps
module mux3_1_err_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mux3_1.sv
// mux3_1: three-input WIDTH-bit selector with illegal-select detection.
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   mux3_1_if.slave: in0/in1/in2/sel in, out/sel_err/err_cnt out
// sel 00/01/10 picks in0/in1/in2; the reserved code 11 yields zeros,
// raises sel_err for the following cycle and bumps err_cnt.
// Build option MUX3_1_OUT_REG_EN: when defined, out is registered
// (1-cycle latency, reset to 0); otherwise out is combinational.
module mux3_1
  import mux3_1_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic     clk,
  input  logic     rst,
  mux3_1_if.slave  bus
);

  logic [WIDTH-1:0] mux_out;
  logic             rsvd;
  logic             sel_err_q;
  logic [CNT_W-1:0] cnt;

  assign rsvd = is_rsvd(bus.sel);

  always_comb begin
    mux_out = '0;
    case (bus.sel)
      SEL_IN0: mux_out = bus.in0;
      SEL_IN1: mux_out = bus.in1;
      SEL_IN2: mux_out = bus.in2;
      default: mux_out = '0;
    endcase
  end

`ifdef MUX3_1_OUT_REG_EN
  logic [WIDTH-1:0] out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= mux_out;
    end
  end

  assign bus.out = out_q;
`else
  assign bus.out = mux_out;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= rsvd;
    end
  end

  mux3_1_err_cnt #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (rsvd),
    .cnt (cnt)
  );

  assign bus.sel_err = sel_err_q;
  assign bus.err_cnt = cnt;

endmodule

// File: tb/tb_mux3_1.sv
// tb_mux3_1: directed self-checking bench for mux3_1 (WIDTH=8, CNT_W=2).
// Works with either build of MUX3_1_OUT_REG_EN.
module tb_mux3_1;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 2;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  mux3_1_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  mux3_1 #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_mux(input logic [1:0] s, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] c);
    case (s)
      2'b00:   return a;
      2'b01:   return b;
      2'b10:   return c;
      default: return 8'h00;
    endcase
  endfunction

  // Drive one vector mid-cycle, then check after the following rising edge.
  task automatic step(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic e_err, input logic [1:0] e_cnt);
    @(negedge clk);
    bus.sel = s;
    bus.in0 = a;
    bus.in1 = b;
    bus.in2 = c;
    #1;
`ifndef MUX3_1_OUT_REG_EN
    check("out_same_cycle", 32'(bus.out), 32'(exp_mux(s, a, b, c)));
`endif
    @(posedge clk);
    #1;
    check("out", 32'(bus.out), 32'(exp_mux(s, a, b, c)));
    check("sel_err", 32'(bus.sel_err), 32'(e_err));
    check("err_cnt", 32'(bus.err_cnt), 32'(e_cnt));
  endtask

  typedef struct {
    logic [1:0] s;
    logic       e_err;
    logic [1:0] e_cnt;
  } rvec_t;

  rvec_t rtab[10];

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    bus.sel = 2'b01;
    bus.in0 = 8'hA5;
    bus.in1 = 8'h3C;
    bus.in2 = 8'hF0;
    #2;
    check("rst_sel_err", 32'(bus.sel_err), 32'd0);
    check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
`ifdef MUX3_1_OUT_REG_EN
    check("rst_out", 32'(bus.out), 32'h00);
`else
    check("rst_out", 32'(bus.out), 32'h3C);
`endif
    @(negedge clk);
    rst = 1'b0;

    // single-bit style sweep pattern, then distinct byte sources
    step(2'b00, 8'hFF, 8'h00, 8'hFF, 1'b0, 2'd0);
    step(2'b01, 8'hFF, 8'h00, 8'hFF, 1'b0, 2'd0);
    step(2'b10, 8'hFF, 8'h00, 8'hFF, 1'b0, 2'd0);
    step(2'b01, 8'hA5, 8'h3C, 8'hF0, 1'b0, 2'd0);
    step(2'b00, 8'hA5, 8'h3C, 8'hF0, 1'b0, 2'd0);
    step(2'b10, 8'hA5, 8'h3C, 8'hF0, 1'b0, 2'd0);

    // three consecutive reserved selects
    step(2'b11, 8'hA5, 8'h3C, 8'hF0, 1'b1, 2'd1);
    step(2'b11, 8'hA5, 8'h3C, 8'hF0, 1'b1, 2'd2);
    step(2'b11, 8'hA5, 8'h3C, 8'hF0, 1'b1, 2'd3);

    // asynchronous reset between edges
    #2;
    bus.sel = 2'b01;
    rst     = 1'b1;
    #1;
    check("async_sel_err", 32'(bus.sel_err), 32'd0);
    check("async_err_cnt", 32'(bus.err_cnt), 32'd0);
`ifdef MUX3_1_OUT_REG_EN
    check("async_out", 32'(bus.out), 32'h00);
`else
    check("async_out", 32'(bus.out), 32'h3C);
`endif
    @(negedge clk);
    rst = 1'b0;

    // first edge after reset samples normally; then saturate
    step(2'b01, 8'h12, 8'h34, 8'h56, 1'b0, 2'd0);
    step(2'b11, 8'h12, 8'h34, 8'h56, 1'b1, 2'd1);
    step(2'b11, 8'h12, 8'h34, 8'h56, 1'b1, 2'd2);
    step(2'b11, 8'h12, 8'h34, 8'h56, 1'b1, 2'd3);
    step(2'b11, 8'h12, 8'h34, 8'h56, 1'b1, 2'd3);
    step(2'b11, 8'h12, 8'h34, 8'h56, 1'b1, 2'd3);
    step(2'b10, 8'h12, 8'h34, 8'h56, 1'b0, 2'd3);

    // random data, sel walking 0..3 from a fresh reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rtab = '{'{2'd0, 1'b0, 2'd0}, '{2'd1, 1'b0, 2'd0}, '{2'd2, 1'b0, 2'd0},
             '{2'd3, 1'b1, 2'd1}, '{2'd0, 1'b0, 2'd1}, '{2'd1, 1'b0, 2'd1},
             '{2'd2, 1'b0, 2'd1}, '{2'd3, 1'b1, 2'd2}, '{2'd0, 1'b0, 2'd2},
             '{2'd1, 1'b0, 2'd2}};
    for (int i = 0; i < 10; i++) begin
      step(rtab[i].s, 8'($urandom), 8'($urandom), 8'($urandom),
           rtab[i].e_err, rtab[i].e_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
